// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and baud divisor helper for the streaming UART transmitter
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Clocks per bit, rounded to the nearest integer.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with combinational head and occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     nRST,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers are exactly AW bits so they wrap on their own.
    always_ff @(posedge clk) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_stream.sv
// rtl/uart_tx_stream.sv - buffered parametrised UART transmitter fed by a valid/ready stream
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int      CLK_HZ     = 50_000_000,
    parameter int      BAUD       = 115200,
    parameter int      DATA_BITS  = 8,
    parameter parity_e PARITY     = PAR_NONE,
    parameter int      STOP_BITS  = 1,
    parameter int      FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            nRST,
    input  logic [DATA_BITS-1:0]            in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic                            uart_tx_line,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    localparam int            DIV       = baud_div(CLK_HZ, BAUD);
    localparam int            CW        = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("uart_tx_stream: illegal parameter combination");
    end

    tx_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   line_q, line_d;
    logic                   bit_end;
    logic                   load;
    logic                   fifo_push;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_BITS-1:0]   fifo_rdata;

    assign in_ready     = !fifo_full;
    assign fifo_push    = in_valid && in_ready;
    assign uart_tx_line = line_q;
    assign busy         = (state_q != IDLE) || (fifo_count != '0);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .nRST  (nRST),
        .push  (fifo_push),
        .pop   (load),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // The line is registered from the current state, so it trails the FSM by one clock.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        line_d  = 1'b1;
        load    = 1'b0;
        bit_end = (cnt_q == CNT_LAST);

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                load = !fifo_empty;
            end
            START: begin
                line_d = 1'b0;
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                line_d = shift_q[0];
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY == PAR_NONE) ? STOP : uart_pkg::PARITY;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            uart_pkg::PARITY: begin
                line_d = par_q;
                if (bit_end) begin
                    state_d = STOP;
                    idx_d   = '0;
                end
            end
            STOP: begin
                line_d = 1'b1;
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        state_d = IDLE;
                        load    = !fifo_empty;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A pop from IDLE or the final stop clock starts the next frame without a gap.
        if (load) begin
            state_d = START;
            cnt_d   = '0;
            idx_d   = '0;
            shift_d = fifo_rdata;
            par_d   = (^fifo_rdata) ^ (PARITY == PAR_ODD);
        end
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            line_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            line_q  <= line_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// tb/tb_uart_tx_stream.sv - directed bench for uart_tx_stream across four frame formats
module tb_uart_tx_stream;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] data_a, data_d;
    logic [6:0] data_b, data_c;
    logic       valid_a, valid_b, valid_c, valid_d;
    logic       ready_a, ready_b, ready_c, ready_d;
    logic       line_a, line_b, line_c, line_d;
    logic       busy_a, busy_b, busy_c, busy_d;
    logic [2:0] cnt_a;
    logic [3:0] cnt_b, cnt_c, cnt_d;

    int tests = 0;
    int fails = 0;

    logic [3:0] rec_q[$];
    bit         rec_en = 1'b0;

    uart_tx_stream #(.CLK_HZ(50_000_000), .BAUD(5_000_000), .DATA_BITS(8), .PARITY(PAR_NONE),
                     .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .nRST(nrst), .in_data(data_a), .in_valid(valid_a), .in_ready(ready_a),
        .uart_tx_line(line_a), .busy(busy_a), .fifo_count(cnt_a));

    uart_tx_stream #(.CLK_HZ(50_000_000), .BAUD(5_000_000), .DATA_BITS(7), .PARITY(PAR_EVEN),
                     .STOP_BITS(1), .FIFO_DEPTH(8)) u_b (
        .clk(clk), .nRST(nrst), .in_data(data_b), .in_valid(valid_b), .in_ready(ready_b),
        .uart_tx_line(line_b), .busy(busy_b), .fifo_count(cnt_b));

    uart_tx_stream #(.CLK_HZ(50_000_000), .BAUD(5_000_000), .DATA_BITS(7), .PARITY(PAR_ODD),
                     .STOP_BITS(1), .FIFO_DEPTH(8)) u_c (
        .clk(clk), .nRST(nrst), .in_data(data_c), .in_valid(valid_c), .in_ready(ready_c),
        .uart_tx_line(line_c), .busy(busy_c), .fifo_count(cnt_c));

    uart_tx_stream #(.CLK_HZ(50_000_000), .BAUD(5_000_000), .DATA_BITS(8), .PARITY(PAR_NONE),
                     .STOP_BITS(2), .FIFO_DEPTH(8)) u_d (
        .clk(clk), .nRST(nrst), .in_data(data_d), .in_valid(valid_d), .in_ready(ready_d),
        .uart_tx_line(line_d), .busy(busy_d), .fifo_count(cnt_d));

    // rec_q[k] holds the four lines just after the k-th edge following rec_start.
    always @(posedge clk) begin
        #1;
        if (rec_en) rec_q.push_back({line_d, line_c, line_b, line_a});
    end

    task automatic rec_start();
        rec_q.delete();
        rec_en = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // bits[0] is the start bit; every bit must hold for 10 recorded clocks.
    task automatic check_frame(input string tag, input int ch, input int base,
                               input logic [15:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            logic [9:0] obs;
            for (int j = 0; j < 10; j++) begin
                int idx;
                idx = base + 10 * i + j;
                obs[j] = (idx < rec_q.size()) ? rec_q[idx][ch] : 1'bx;
            end
            chk($sformatf("%s bit%0d", tag, i), {22'd0, obs}, {22'd0, {10{bits[i]}}});
        end
    endtask

    initial begin
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0; valid_d = 1'b0;
        data_a = '0; data_b = '0; data_c = '0; data_d = '0;
        repeat (3) @(negedge clk);
        chk("rst line", {line_d, line_c, line_b, line_a}, 4'hF);
        chk("rst ready", {ready_d, ready_c, ready_b, ready_a}, 4'hF);
        chk("rst busy", {busy_d, busy_c, busy_b, busy_a}, 4'h0);
        chk("rst count", {cnt_d, cnt_c, cnt_b, 1'b0, cnt_a}, 16'h0);
        nrst = 1'b1;
        @(negedge clk);

        // Single frame on all four formats, pushed at the same edge N.
        data_a = 8'h48; data_b = 7'h48; data_c = 7'h48; data_d = 8'h48;
        valid_a = 1'b1; valid_b = 1'b1; valid_c = 1'b1; valid_d = 1'b1;
        rec_start();
        @(negedge clk);
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0; valid_d = 1'b0;
        chk("push count", cnt_a, 1);
        chk("line N", line_a, 1);
        @(negedge clk);
        chk("pop count", cnt_a, 0);
        chk("busy in frame", busy_a, 1);
        chk("line N+1", line_a, 1);
        @(negedge clk);
        chk("line N+2 start", line_a, 0);
        repeat (99) @(negedge clk);
        chk("busy end 1stop", {busy_d, busy_c, busy_b, busy_a}, 4'h8);
        repeat (10) @(negedge clk);
        chk("busy end 2stop", busy_d, 0);
        repeat (5) @(negedge clk);
        check_frame("8N1", 0, 2, {1'b1, 8'h48, 1'b0}, 10);
        check_frame("7E1", 1, 2, {1'b1, 1'b0, 7'h48, 1'b0}, 10);
        check_frame("7O1", 2, 2, {1'b1, 1'b1, 7'h48, 1'b0}, 10);
        check_frame("8N2", 3, 2, {1'b1, 1'b1, 8'h48, 1'b0}, 11);
        chk("8N2 idle after", rec_q[112][3], 1);

        // Five words back-to-back into a depth-4 FIFO, then a held word while full.
        valid_a = 1'b1; data_a = 8'h48;
        rec_start();
        @(negedge clk); data_a = 8'hA5;
        @(negedge clk); chk("push+pop at 1", cnt_a, 1); data_a = 8'h3C;
        @(negedge clk); data_a = 8'hFF;
        @(negedge clk); chk("ready at 3", ready_a, 1); data_a = 8'h01;
        @(negedge clk);
        chk("full count", cnt_a, 4);
        chk("full ready", ready_a, 0);
        data_a = 8'hEE;
        repeat (5) @(negedge clk);
        chk("full ignores push", cnt_a, 4);
        valid_a = 1'b0;
        repeat (500) @(negedge clk);
        chk("burst busy end", busy_a, 0);
        chk("burst count end", cnt_a, 0);
        check_frame("burst0", 0, 2,   {1'b1, 8'h48, 1'b0}, 10);
        check_frame("burst1", 0, 102, {1'b1, 8'hA5, 1'b0}, 10);
        check_frame("burst2", 0, 202, {1'b1, 8'h3C, 1'b0}, 10);
        check_frame("burst3", 0, 302, {1'b1, 8'hFF, 1'b0}, 10);
        check_frame("burst4", 0, 402, {1'b1, 8'h01, 1'b0}, 10);
        chk("no extra frame", rec_q[502][0], 1);

        // Push coinciding with the pop at the last stop clock, two words queued.
        valid_a = 1'b1; data_a = 8'h55;
        rec_start();
        @(negedge clk); data_a = 8'h81;
        @(negedge clk); data_a = 8'h7E;
        @(negedge clk); valid_a = 1'b0;
        chk("queued two", cnt_a, 2);
        repeat (98) @(negedge clk);
        chk("pre simul count", cnt_a, 2);
        valid_a = 1'b1; data_a = 8'hC3;
        @(negedge clk); valid_a = 1'b0;
        chk("simul push+pop count", cnt_a, 2);
        chk("last stop clock", line_a, 1);
        @(negedge clk);
        chk("next start", line_a, 0);
        repeat (320) @(negedge clk);
        chk("simul busy end", busy_a, 0);
        check_frame("simul0", 0, 2,   {1'b1, 8'h55, 1'b0}, 10);
        check_frame("simul1", 0, 102, {1'b1, 8'h81, 1'b0}, 10);
        check_frame("simul2", 0, 202, {1'b1, 8'h7E, 1'b0}, 10);
        check_frame("simul3", 0, 302, {1'b1, 8'hC3, 1'b0}, 10);

        // Reset during data bit 3 with two words still queued.
        valid_a = 1'b1; data_a = 8'h00;
        @(negedge clk); data_a = 8'h5A;
        @(negedge clk); data_a = 8'h33;
        @(negedge clk); valid_a = 1'b0;
        repeat (42) @(negedge clk);
        chk("mid data line", line_a, 0);
        chk("mid data busy", busy_a, 1);
        chk("mid data count", cnt_a, 2);
        nrst = 1'b0;
        @(negedge clk);
        chk("abort line", line_a, 1);
        chk("abort count", cnt_a, 0);
        chk("abort busy", busy_a, 0);
        chk("abort ready", ready_a, 1);
        nrst = 1'b1;
        repeat (20) @(negedge clk);
        chk("post abort line", line_a, 1);
        chk("post abort busy", busy_a, 0);
        valid_a = 1'b1; data_a = 8'hB2;
        rec_start();
        @(negedge clk); valid_a = 1'b0;
        repeat (105) @(negedge clk);
        chk("after reset busy", busy_a, 0);
        check_frame("after reset", 0, 2, {1'b1, 8'hB2, 1'b0}, 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
